// File: rtl/sev_seg_scanner.sv
// rtl/sev_seg_scanner.sv - multiplexed seven-segment scanner with shadowed value, blanking, PWM and blink
module sev_seg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int SLOT_W     = 14,
    parameter int BRIGHT_W   = 3,
    parameter int BLINK_W    = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = '1;

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BLINK_W-1:0]      blink_cnt;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    pend_valid;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_blink;
    logic                    lead_blank;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    bright_ok;
    logic                    lit;
    logic [6:0]              seg_dec;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (idx == LAST_IDX);

    // Scan timing: slot counter, digit index and per-frame blink counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (frame_end) begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Shadow registers: loads are held in pending and only reach the display at a frame boundary,
    // a load in the boundary cycle itself bypasses pending so it is not delayed a whole frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
        end else if (frame_end) begin
            if (load) begin
                act_value <= value;
                act_dp    <= dp_in;
            end else if (pend_valid) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end
    end

    // Select the current digit's data; zero_above accumulates "this and all higher nibbles are zero"
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        cur_blink  = 1'b0;
        lead_blank = 1'b0;
        zero_above = 1'b1;
        an_sel     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_value[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                cur_nib    = act_value[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_en     = digit_en[i];
                cur_blink  = blink_mask[i];
                lead_blank = zero_above && (i != 0);
                an_sel[i]  = 1'b1;
            end
        end
    end

    // Lit decision: slot 0 is a dead cycle against ghosting, PWM compares the slot's top bits
    always_comb begin
        bright_ok = (&brightness) || (slot_cnt[SLOT_W-1 -: BRIGHT_W] < brightness);
        lit = cur_en && (slot_cnt != '0) && bright_ok &&
              !(cur_blink && blink_cnt[BLINK_W-1]) && !(lz_blank && lead_blank);
    end

    // Hex to active-low {g,f,e,d,c,b,a}
    always_comb begin
        case (cur_nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    end

    // Registered pin drivers; everything blank when no digit is lit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg         <= 7'h7F;
            dp          <= 1'b1;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            seg         <= lit ? seg_dec : 7'h7F;
            dp          <= lit ? ~cur_dp : 1'b1;
            an          <= lit ? ~an_sel : '1;
            frame_start <= (idx == '0) && (slot_cnt == '0);
        end
    end

endmodule

// File: tb/tb_sev_seg_scanner.sv
// tb/tb_sev_seg_scanner.sv - scoreboard bench for sev_seg_scanner against a time-based display model
module tb_sev_seg_scanner;

    localparam int ND    = 4;
    localparam int SW    = 4;
    localparam int BW    = 2;
    localparam int KW    = 2;
    localparam int SLOT  = 16;
    localparam int FRAME = SLOT * ND;

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic [15:0]   value      = 16'h0;
    logic [3:0]    dp_in      = 4'h0;
    logic          load       = 1'b0;
    logic [3:0]    digit_en   = 4'hF;
    logic          lz_blank   = 1'b0;
    logic [1:0]    brightness = 2'd3;
    logic [3:0]    blink_mask = 4'h0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_start;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    // model state: k counts clock edges since reset release
    int          k = 0;
    logic [15:0] act_v = 16'h0;
    logic [3:0]  act_d = 4'h0;
    logic [15:0] lat_v = 16'h0;
    logic [3:0]  lat_d = 4'h0;
    int          m_slot, m_dig, m_frame;
    bit          m_lit;
    exp_t        m_e;
    exp_t        mon_e;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam exp_t RST_E = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fs: 1'b0};

    sev_seg_scanner #(
        .NUM_DIGITS (ND),
        .SLOT_W     (SW),
        .BRIGHT_W   (BW),
        .BLINK_W    (KW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .value       (value),
        .dp_in       (dp_in),
        .load        (load),
        .digit_en    (digit_en),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .blink_mask  (blink_mask),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("an", int'(an), int'(e.an));
        chk("seg", int'(seg), int'(e.seg));
        chk("dp", int'(dp), int'(e.dp));
        chk("frame_start", int'(frame_start), int'(e.fs));
    endtask

    // Reference model: position in time gives slot, digit and frame; the shown value is the last
    // load sampled before the current frame began
    initial forever begin
        @(posedge clk);
        if (!resetn) begin
            q.push_back(RST_E);
            k = 0;
            act_v = 16'h0; act_d = 4'h0;
            lat_v = 16'h0; lat_d = 4'h0;
        end else begin
            m_slot  = k % SLOT;
            m_dig   = (k / SLOT) % ND;
            m_frame = k / FRAME;
            m_lit = digit_en[m_dig] && (m_slot != 0) &&
                    (brightness == 2'd3 || (m_slot / 4) < int'(brightness)) &&
                    !(blink_mask[m_dig] && (m_frame % 4) >= 2) &&
                    !(lz_blank && m_dig > 0 && (act_v >> (4 * m_dig)) == 16'h0);
            m_e.fs  = (k % FRAME) == 0;
            m_e.an  = m_lit ? ~(4'h1 << m_dig) : 4'hF;
            m_e.seg = m_lit ? seg_tab[(act_v >> (4 * m_dig)) & 16'hF] : 7'h7F;
            m_e.dp  = m_lit ? ~act_d[m_dig] : 1'b1;
            q.push_back(m_e);
            if (load) begin
                lat_v = value;
                lat_d = dp_in;
            end
            k++;
            if ((k % FRAME) == 0) begin
                act_v = lat_v;
                act_d = lat_d;
            end
        end
    end

    // Monitor: every cycle presents outputs; compare them on the falling edge
    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            if (q.size() > 0) void'(q.pop_front());
            chk_all(RST_E);
        end else if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk_all(mon_e);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Stop at the negedge just before the frame's last edge
    task automatic wait_boundary();
        int t;
        t = 0;
        while ((k % FRAME) != FRAME - 1 && t < 2 * FRAME) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2 * FRAME) begin
            checks++;
            errors++;
            $display("FAIL boundary_wait: got timeout want boundary within %0d cycles", 2 * FRAME);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(5);
        resetn = 1'b1;
        cycles(2 * FRAME);

        // mid-frame load, then two loads inside one frame
        cycles(20);
        do_load(16'h12AF, 4'b0100);
        cycles(2 * FRAME);
        wait_boundary();
        cycles(10);
        do_load(16'h3456, 4'b0011);
        cycles(5);
        do_load(16'hC0DE, 4'b1001);
        cycles(2 * FRAME);

        // leading-zero blanking
        lz_blank = 1'b1;
        do_load(16'h0050, 4'b0000);
        cycles(2 * FRAME);
        do_load(16'h0000, 4'b0000);
        cycles(2 * FRAME);
        lz_blank = 1'b0;
        do_load(16'h8421, 4'b1111);

        // brightness levels
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            brightness = 2'(b);
            cycles(FRAME + 7);
        end
        brightness = 2'd3;

        // blink on digit 0 over more than one blink period
        blink_mask = 4'b0001;
        cycles(5 * FRAME);
        blink_mask = 4'b0000;

        // load landing exactly on the boundary edge
        wait_boundary();
        value = 16'h9876;
        dp_in = 4'b1010;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        cycles(FRAME + 3);

        // randomized stimulus
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            load = ($urandom_range(0, 19) == 0);
            if (load) begin
                value = 16'($urandom);
                dp_in = 4'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                digit_en   = 4'($urandom);
                lz_blank   = 1'($urandom);
                brightness = 2'($urandom);
                blink_mask = 4'($urandom);
            end
        end
        @(negedge clk);
        load       = 1'b0;
        digit_en   = 4'hF;
        lz_blank   = 1'b0;
        brightness = 2'd3;
        blink_mask = 4'h0;
        cycles(2 * FRAME);

        // async reset mid-slot with a load pending
        wait_boundary();
        cycles(10);
        do_load(16'hFFFF, 4'hF);
        cycles(3);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_an", int'(an), 4'hF);
        chk("async_seg", int'(seg), 7'h7F);
        chk("async_dp", int'(dp), 1);
        chk("async_fs", int'(frame_start), 0);
        cycles(3);
        resetn = 1'b1;
        cycles(2 * FRAME);

        cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
